// File: rtl/led_fade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_pkg
//  Description : Shared FSM encodings and helpers for the LED fade stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_fade_pkg;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  // Full-scale duty for a PWM counter of the given width.
  function automatic int duty_max_f(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchroniser, async active-low reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/led_fade.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade
//  Description : Turns a 1-bit blink level into a PWM brightness ramp
//                (soft fade-in / fade-out) for one LED channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_fade
  import led_fade_pkg::*;
#(
  parameter int PWM_W        = 8,
  parameter int STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             led_in,
  output logic             led_out,
  output logic [PWM_W-1:0] duty,
  output logic             busy
);

  localparam int               PER_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PWM_W-1:0] DUTY_MAX = PWM_W'(duty_max_f(PWM_W));
  localparam logic [PWM_W-1:0] DUTY_MIN = '0;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIODS - 1);

  logic             lvl;
  logic             tick;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PWM_W-1:0] duty_q,    duty_d;
  logic [1:0]       state_q,   state_d;
  logic             busy_q,    busy_d;
  logic             led_q,     led_d;

  sync_2ff u_sync_led_in (
    .clk (clk),
    .rst (rst),
    .d   (led_in),
    .q   (lvl)
  );

  // PWM counter free-runs; period counter advances on each PWM wrap.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    per_cnt_d = per_cnt_q;
    tick      = (pwm_cnt_q == DUTY_MAX) && (per_cnt_q == PER_LAST);
    if (!en) begin
      pwm_cnt_d = '0;
      per_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (pwm_cnt_q == DUTY_MAX) begin
        per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
      end
    end
  end

  // Duty steps only on tick, in the direction of the current level, so a
  // reversal continues from the present value and a same-cycle direction
  // change applies the new direction. Saturates at both ends.
  always_comb begin
    duty_d = duty_q;
    if (!en) begin
      duty_d = '0;
    end else if (tick) begin
      if (lvl && (duty_q != DUTY_MAX)) begin
        duty_d = duty_q + 1'b1;
      end else if (!lvl && (duty_q != DUTY_MIN)) begin
        duty_d = duty_q - 1'b1;
      end
    end
  end

  // Next-state logic: the ramp ends when the stepped duty hits an end stop.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (lvl) state_d = (duty_d == DUTY_MAX) ? ST_ON : ST_RISE;
        end
        ST_RISE: begin
          if (!lvl)                    state_d = (duty_d == DUTY_MIN) ? ST_OFF : ST_FALL;
          else if (duty_d == DUTY_MAX) state_d = ST_ON;
        end
        ST_ON: begin
          if (!lvl) state_d = (duty_d == DUTY_MIN) ? ST_OFF : ST_FALL;
        end
        ST_FALL: begin
          if (lvl)                     state_d = (duty_d == DUTY_MAX) ? ST_ON : ST_RISE;
          else if (duty_d == DUTY_MIN) state_d = ST_OFF;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs: busy tracks the next state; PWM compare is registered once.
  always_comb begin
    busy_d = (state_d == ST_RISE) || (state_d == ST_FALL);
    led_d  = en && ((pwm_cnt_q < duty_q) || (duty_q == DUTY_MAX));
  end

  // All state registers; reset forces the channel dark immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      per_cnt_q <= '0;
      duty_q    <= '0;
      state_q   <= ST_OFF;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      per_cnt_q <= per_cnt_d;
      duty_q    <= duty_d;
      state_q   <= state_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;
  assign duty    = duty_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_fade.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fade
//  Description : Scoreboard bench for led_fade (PWM_W=4, STEP_PERIODS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade;

  logic       clk;
  logic       rst;
  logic       en;
  logic       led_in;
  logic       led_out;
  logic [3:0] duty;
  logic       busy;

  int          errors;
  int          checks;
  bit          mon_en;
  logic [3:0]  prev_duty;
  logic [3:0]  exp_q[$];
  int unsigned ncyc;
  int unsigned t0;

  led_fade #(.PWM_W(4), .STEP_PERIODS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .led_in  (led_in),
    .led_out (led_out),
    .duty    (duty),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue the duty values expected from one ramp, in order.
  task automatic push_range(input int from, input int to);
    if (from <= to) for (int v = from; v <= to; v++) exp_q.push_back(4'(v));
    else            for (int v = from; v >= to; v--) exp_q.push_back(4'(v));
  endtask

  task automatic wait_duty(input int val, input int maxc);
    int n;
    n = 0;
    while ((int'(duty) != val) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    if (int'(duty) != val) begin
      checks++;
      errors++;
      $display("FAIL wait_duty timeout: got %0d expected %0d", duty, val);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (16) begin
      @(negedge clk);
      n += int'(led_out);
    end
  endtask

  // Monitor: every observed duty change must match the next queued value.
  initial begin
    logic [3:0] e;
    prev_duty = '0;
    forever begin
      @(negedge clk);
      if (mon_en && (duty !== prev_duty)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL duty_change: got %0d expected no change", duty);
        end else begin
          e = exp_q.pop_front();
          if (duty !== e) begin
            errors++;
            $display("FAIL duty_seq: got %0d expected %0d", duty, e);
          end
        end
      end
      prev_duty = duty;
    end
  end

  initial begin
    int n;
    int unsigned tm;
    errors = 0; checks = 0; mon_en = 1'b0; ncyc = 0;
    rst = 1'b1; en = 1'b1; led_in = 1'b1;
    #1 rst = 1'b0;

    // 1. Reset holds everything dark, then a full rise.
    repeat (3) @(negedge clk);
    check("reset_led_out", int'(led_out), 0);
    check("reset_duty",    int'(duty),    0);
    check("reset_busy",    int'(busy),    0);
    mon_en = 1'b1;
    push_range(1, 15);
    rst = 1'b1;
    t0  = ncyc;
    repeat (2) @(negedge clk);
    check("busy_before_edge3", int'(busy), 0);
    @(negedge clk);
    check("busy_at_edge3", int'(busy), 1);
    wait_duty(1, 60);
    check("first_tick_cycle", int'(ncyc - t0), 32);

    // 2. PWM shape at duty 5 and at full scale.
    wait_duty(5, 200);
    count_high(n);
    check("pwm_high_duty5", n, 5);
    wait_duty(15, 400);
    check("full_rise_cycle", int'(ncyc - t0), 480);
    check("on_busy", int'(busy), 0);
    count_high(n);
    check("pwm_high_duty15", n, 16);

    // 4a. Extra ticks while ON do not wrap.
    repeat (70) @(negedge clk);
    check("on_saturate", int'(duty), 15);

    // Full fall, then dark and saturated at 0.
    led_in = 1'b0;
    push_range(14, 0);
    wait_duty(0, 600);
    check("off_busy", int'(busy), 0);
    count_high(n);
    check("pwm_high_duty0", n, 0);
    repeat (70) @(negedge clk);
    check("off_saturate", int'(duty), 0);

    // 3. Reversal at duty 9 in RISE.
    led_in = 1'b1;
    push_range(1, 9);
    wait_duty(9, 400);
    check("rise_busy", int'(busy), 1);
    led_in = 1'b0;
    push_range(8, 0);
    tm = ncyc;
    repeat (6) @(negedge clk);
    check("reverse_busy", int'(busy), 1);
    wait_duty(8, 40);
    check("reverse_step_cycle", int'(ncyc - tm), 32);
    wait_duty(0, 400);
    check("reverse_end_busy", int'(busy), 0);

    // 5. Enable drop mid-FALL at duty 7, then restart from 0.
    led_in = 1'b1;
    push_range(1, 8);
    wait_duty(8, 400);
    led_in = 1'b0;
    exp_q.push_back(4'd7);
    wait_duty(7, 40);
    check("fall_busy", int'(busy), 1);
    en = 1'b0;
    exp_q.push_back(4'd0);
    @(negedge clk);
    check("en_drop_duty",    int'(duty),    0);
    check("en_drop_led_out", int'(led_out), 0);
    check("en_drop_busy",    int'(busy),    0);
    repeat (40) @(negedge clk);
    check("en_low_hold", int'(duty), 0);
    en = 1'b1;
    led_in = 1'b1;
    exp_q.push_back(4'd1);
    tm = ncyc;
    wait_duty(1, 60);
    check("en_restart_cycle", int'(ncyc - tm), 32);
    check("en_restart_busy",  int'(busy), 1);

    // 6. Async reset between edges mid-RISE.
    push_range(2, 3);
    wait_duty(3, 80);
    exp_q.push_back(4'd0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_duty",    int'(duty),    0);
    check("async_rst_led_out", int'(led_out), 0);
    check("async_rst_busy",    int'(busy),    0);
    @(negedge clk);
    led_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Sub-cycle glitch between edges must leave clean outputs.
    @(negedge clk);
    #1 led_in = 1'b1;
    #3 led_in = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_no_x", int'($isunknown({duty, led_out, busy})), 0);
    check("glitch_duty", int'(duty), 0);
    check("glitch_busy", int'(busy), 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
